// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys expanded once per key load.
// Define AES_DEC_CBC_EN to add the iv port and CBC chaining; the default build is plain ECB.
`timescale 1ns/1ps

module aes128_decrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         in_valid,
  input  logic [127:0] cipher_text,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] plain_text,
  input  logic         out_ready
`ifdef AES_DEC_CBC_EN
  ,
  input  logic [127:0] iv
`endif
);

  localparam logic [2:0] S_NOKEY  = 3'd0;
  localparam logic [2:0] S_KEYEXP = 3'd1;
  localparam logic [2:0] S_READY  = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, polynomial 0x11B
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  // Returns {0e*a, 0b*a, 0d*a, 09*a} from a single xtime chain.
  function automatic logic [31:0] mul_set(input logic [7:0] a);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] m2;
    logic [31:0] m3;
    m0 = mul_set(c[31:24]);
    m1 = mul_set(c[23:16]);
    m2 = mul_set(c[15:8]);
    m3 = mul_set(c[7:0]);
    return {m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0],
            m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8],
            m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16],
            m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24]};
  endfunction

  // ---------------------------------------------------------------------------
  // Block-level transforms; byte 0 sits in bits [127:120], columns are 4 bytes
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[120 - 8 * (4 * c + r) +: 8] = s[120 - 8 * (4 * ((c + 4 - r) % 4) + r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8 * i +: 8] = inv_sbox(s[8 * i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[32 * c +: 32] = inv_mix_col(s[32 * c +: 32]);
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3;
    logic [31:0] t;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    return {n0, n1, n2, w3 ^ n2};
  endfunction

  // ---------------------------------------------------------------------------
  // Control and datapath
  // ---------------------------------------------------------------------------
  logic [2:0]   fsm;
  logic [2:0]   next_fsm;
  logic [3:0]   kcnt;
  logic [3:0]   rcnt;
  logic [127:0] st_q;
  logic [127:0] rk [0:10];
  logic [127:0] rk_next;
  logic [127:0] ark;
  logic [127:0] round_out;
  logic [127:0] dec_out;
  logic         key_acc;
  logic         blk_acc;
  logic         out_acc;

`ifdef AES_DEC_CBC_EN
  logic [127:0] chain;
  logic [127:0] ct_hold;
  assign dec_out = round_out ^ chain;
`else
  assign dec_out = round_out;
`endif

  assign in_ready  = (fsm == S_READY) && !key_valid;
  assign out_valid = (fsm == S_DONE);
  assign key_acc   = key_valid && key_ready;
  assign blk_acc   = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;

  assign rk_next   = expand_key(rk[kcnt], rcon(kcnt));
  assign ark       = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk[rcnt];
  assign round_out = (rcnt == 4'd0) ? ark : inv_mix_cols(ark);

  // NOTE: next_fsm gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_fsm = fsm;
    case (fsm)
      S_NOKEY:  if (key_acc) next_fsm = S_KEYEXP;
      S_KEYEXP: if (kcnt == 4'd9) next_fsm = S_READY;
      S_READY: begin
        if (key_acc)      next_fsm = S_KEYEXP;
        else if (blk_acc) next_fsm = S_ROUND;
      end
      S_ROUND:  if (rcnt == 4'd0) next_fsm = S_DONE;
      S_DONE:   if (out_acc) next_fsm = S_READY;
      default:  next_fsm = S_NOKEY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the round-key file is reset explicitly so a reset wipes the old schedule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= S_NOKEY;
      key_ready  <= 1'b0;
      kcnt       <= 4'd0;
      rcnt       <= 4'd0;
      st_q       <= '0;
      plain_text <= '0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
`ifdef AES_DEC_CBC_EN
      chain      <= '0;
      ct_hold    <= '0;
`endif
    end else begin
      fsm       <= next_fsm;
      // key_ready is registered so it stays low through reset and rises one clock after release.
      key_ready <= (next_fsm == S_NOKEY) || (next_fsm == S_READY);
      if (key_acc) begin
        rk[0] <= key;
        kcnt  <= 4'd0;
`ifdef AES_DEC_CBC_EN
        chain <= iv;
`endif
      end
      if (fsm == S_KEYEXP) begin
        rk[kcnt + 4'd1] <= rk_next;
        kcnt            <= kcnt + 4'd1;
      end
      if (blk_acc) begin
        st_q <= cipher_text ^ rk[10];
        rcnt <= 4'd9;
`ifdef AES_DEC_CBC_EN
        ct_hold <= cipher_text;
`endif
      end
      if (fsm == S_ROUND) begin
        st_q <= round_out;
        if (rcnt == 4'd0) plain_text <= dec_out;
        else              rcnt <= rcnt - 4'd1;
      end
`ifdef AES_DEC_CBC_EN
      if (out_acc) chain <= ct_hold;
`endif
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Self-checking bench for aes128_decrypt_iter: FIPS-197 / SP800-38A vectors, latency,
// backpressure, key/data collision and mid-round reset. CBC checks run when AES_DEC_CBC_EN is defined.
`timescale 1ns/1ps

module tb_aes128_decrypt_iter;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic [127:0] key = '0;
  logic         key_ready;
  logic         in_valid = 1'b0;
  logic [127:0] cipher_text = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] plain_text;
  logic         out_ready = 1'b0;
`ifdef AES_DEC_CBC_EN
  logic [127:0] iv = '0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q [$];

  aes128_decrypt_iter dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key         (key),
    .key_ready   (key_ready),
    .in_valid    (in_valid),
    .cipher_text (cipher_text),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .plain_text  (plain_text),
    .out_ready   (out_ready)
`ifdef AES_DEC_CBC_EN
    ,
    .iv          (iv)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Counts clocks from the key transfer until key_ready returns; nothing else may be offered meanwhile.
  task automatic wait_keyexp(input string name);
    int  w;
    logic leak;
    w = 0;
    leak = 1'b0;
    while (!key_ready && w < 50) begin
      if (in_ready || out_valid) leak = 1'b1;
      @(negedge clk);
      w++;
    end
    check({name, " keyexp clocks"}, 128'(w), 128'd10);
    check({name, " keyexp idle"}, 128'(leak), 128'd0);
  endtask

  task automatic load_key(input string name, input logic [127:0] k);
    int w;
    w = 0;
    while (!key_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!key_ready) begin
      timeout({name, " key_ready"});
      return;
    end
    key_valid = 1'b1;
    key       = k;
    @(negedge clk);
    key_valid = 1'b0;
    wait_keyexp(name);
  endtask

  task automatic send_block(input string name, input logic [127:0] ct, input logic [127:0] exp);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      timeout({name, " in_ready"});
      return;
    end
    in_valid    = 1'b1;
    cipher_text = ct;
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 128'(lat), 128'd10);
  endtask

  task automatic take_out(input string name);
    logic [127:0] exp;
    if (exp_q.size() == 0) begin
      timeout({name, " no expected result queued"});
      return;
    end
    exp = exp_q.pop_front();
    if (!out_valid) begin
      timeout({name, " out_valid"});
      return;
    end
    check({name, " plain_text"}, plain_text, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid clear"}, 128'(out_valid), 128'd0);
    check({name, " in_ready after"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    vec_t         vecs [6];
    logic [127:0] cur_key;

    vecs[0] = '{K_B,  128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[1] = '{K_B,  128'hf5d3d58503b9699de785895a96fdbaaf, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
    vecs[2] = '{K_B,  128'h43b1cd7f598ece23881b00e3ed030688, 128'h30c81c46a35ce411e5fbc1191a0a52ef};
    vecs[3] = '{K_B,  128'h7b0c785e27e8ad3f8223207104725dd4, 128'hf69f2445df4f9b17ad2b417be66c3710};
    vecs[4] = '{K_C1, CT_C1, PT_C1};
    vecs[5] = '{K_B,  CT_B,  PT_B};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset key_ready", 128'(key_ready), 128'd0);
    check("reset in_ready", 128'(in_ready), 128'd0);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset plain_text", plain_text, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check("release key_ready", 128'(key_ready), 128'd1);
    check("release in_ready", 128'(in_ready), 128'd0);

    // FIPS-197 C.1, then re-key straight to FIPS-197 B
    load_key("c1", K_C1);
    send_block("c1", CT_C1, PT_C1);
    wait_out("c1");
    take_out("c1");
    load_key("b", K_B);
    send_block("b", CT_B, PT_B);
    wait_out("b");
    take_out("b");

`ifndef AES_DEC_CBC_EN
    // ECB vector table; re-key only when the key changes
    cur_key = K_B;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].key != cur_key) begin
        load_key($sformatf("vec%0d", i), vecs[i].key);
        cur_key = vecs[i].key;
      end
      send_block($sformatf("vec%0d", i), vecs[i].ct, vecs[i].pt);
      wait_out($sformatf("vec%0d", i));
      take_out($sformatf("vec%0d", i));
    end
`else
    cur_key = '0;
    if (cur_key != '0) take_out("unused");
`endif

    // Backpressure: out_ready low for 20 clocks after out_valid
    load_key("bp", K_C1);
    send_block("bp", CT_C1, PT_C1);
    wait_out("bp");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("bp hold %0d plain_text", i), plain_text, PT_C1);
      check($sformatf("bp hold %0d ready", i), {126'd0, out_valid, in_ready}, 128'd2);
    end
    take_out("bp");

    // Key and ciphertext offered together in READY: key wins
    key_valid   = 1'b1;
    key         = K_B;
    in_valid    = 1'b1;
    cipher_text = CT_C1;
    #1;
    check("collide in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    key_valid = 1'b0;
    in_valid  = 1'b0;
    wait_keyexp("collide");
    send_block("collide", CT_B, PT_B);
    wait_out("collide");
    take_out("collide");

    // Reset while round r=4 is pending (after E5), then recover with C.1
    load_key("rst", K_C1);
    send_block("rst", CT_C1, PT_C1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("midrst out_valid", 128'(out_valid), 128'd0);
    check("midrst plain_text", plain_text, 128'd0);
    check("midrst key_ready", 128'(key_ready), 128'd0);
    check("midrst in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst release key_ready", 128'(key_ready), 128'd1);
    check("midrst release out_valid", 128'(out_valid), 128'd0);
    load_key("post_rst", K_C1);
    send_block("post_rst", CT_C1, PT_C1);
    wait_out("post_rst");
    take_out("post_rst");

`ifdef AES_DEC_CBC_EN
    // SP800-38A F.2.2 CBC decryption
    iv = 128'h000102030405060708090a0b0c0d0e0f;
    load_key("cbc", K_B);
    send_block("cbc1", 128'h7649abac8119b246cee98e9b12e9197d, 128'h6bc1bee22e409f96e93d7e117393172a);
    wait_out("cbc1");
    take_out("cbc1");
    send_block("cbc2", 128'h5086cb9b507219ee95db113a917678b2, 128'hae2d8a571e03ac9c9eb76fac45af8e51);
    wait_out("cbc2");
    take_out("cbc2");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
